fast_core_indirect_reader: RTL and testbench
============================================

// Module: fast_core_indirect_reader
// PURPOSE
// - Read-side partner of the R0/R1 register bank: resolves @R0/@R1 indirect operands for the core.
// - Accepts one request, selects the pointer (R0/R1 of active bank, write-bypassed), issues one data-memory read, returns the byte.
// - Supports internal RAM (@Ri, page 0x00) and external RAM (MOVX @Ri, page = P2); bounded wait with timeout error.
// PARAMETERS
// - TIMEOUT_CYCLES  16  max cycles in WAIT before aborting with rsp_err; legal range 2..256
// PORTS
// - clk                input   1   core clock
// - reset_n            input   1   asynchronous, active-low reset
// - active_bank_index  input   2   PSW.RS[1:0], selects register bank
// - R0 / R1            input   8   R0/R1 of active bank from register bank
// - wr_addr            input   16  data-memory write address (snooped)
// - wr_data            input   8   data-memory write data (snooped)
// - we                 input   1   data-memory write enable (snooped)
// - p2_page            input   8   P2 SFR, high address byte for MOVX
// - req_valid          input   1   operand request
// - req_ready          output  1   block can accept request (state IDLE)
// - req_ri_sel         input   1   0 = @R0, 1 = @R1
// - req_xdata          input   1   0 = internal RAM, 1 = external RAM (MOVX)
// - mem_rd_req         output  1   one-cycle read strobe to memory
// - mem_rd_addr        output  16  read address, stable from ISSUE until RESP
// - mem_rd_xdata       output  1   read targets external RAM
// - mem_rd_ack         input   1   one-cycle pulse, mem_rd_data valid
// - mem_rd_data        input   8   read data
// - rsp_valid          output  1   response valid, held until rsp_ready
// - rsp_ready          input   1   consumer accepts response
// - rsp_data           output  8   operand byte (0xFF on error)
// - rsp_addr           output  16  resolved address (for debug/trace)
// - rsp_err            output  1   timeout occurred
// BEHAVIOUR
// - Reset: state IDLE, req_ready=1 after reset release; mem_rd_req=0, mem_rd_addr=0, mem_rd_xdata=0,
//   rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_err=0, timeout counter=0. Reset mid-operation abandons transfer; late ack ignored.
// - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; all outputs registered.
// - IDLE: req_valid & req_ready accepts (cycle N). Pointer ptr = selected Ri; bypass: if we and
//   wr_addr == {11'b0, active_bank_index, 2'b00, req_ri_sel} in cycle N, ptr = wr_data.
// - Address: internal -> {8'h00, ptr}; external -> {p2_page, ptr}; both sampled in cycle N only.
// - ISSUE (N+1): mem_rd_req=1 for exactly one cycle; ack sampled here too (zero-wait memory).
// - WAIT: counter increments each cycle; ack -> capture data, go RESP. Counter == TIMEOUT_CYCLES-1
//   without ack -> RESP, rsp_err=1, rsp_data=0xFF. Ack and timeout same cycle: ack wins, rsp_err=0.
// - Min latency: accept N, rsp_valid N+2 (ack at N+1).
// - RESP: rsp_valid held with stable rsp_* until rsp_ready; handshake cycle -> IDLE, rsp_valid=0 next cycle.
//   No new request accepted in the handshake cycle (one idle cycle between transfers).
// - Writes to Ri after cycle N do not alter an in-flight address; bank switches after N likewise ignored.
// - mem_rd_ack in IDLE/RESP ignored; mem_rd_addr holds last value in IDLE.
// STRUCTURE
// - Shared package fast_core_indirect_pkg: state enum (IDLE/ISSUE/WAIT/RESP), XDATA/IDATA page constants,
//   error byte 8'hFF, Ri-address compose function {11'b0, bank, 2'b00, sel}.
// - One sub-module: fast_core_ri_bypass_sel (combinational pointer select + write bypass); FSM, counter in top.
// TESTING
// - Bank 2, R1=0x45, request idata @R1, ack next cycle data 0x3C -> mem_rd_addr 0x0045, rsp_data 0x3C at N+2, rsp_err 0.
// - Bank 1, R0=0x10, same cycle we to 0x0008 data 0x77 -> mem_rd_addr 0x0077 (bypass); write to 0x0010 not bypassed.
// - MOVX @R0, p2_page=0x12, R0=0xA0, ack after 5 cycles data 0x99 -> mem_rd_xdata 1, addr 0x12A0, rsp_data 0x99.
// - No ack, TIMEOUT_CYCLES=16 -> rsp_err 1, rsp_data 0xFF; later stray ack ignored, req_ready back to 1.
// - rsp_ready held low 4 cycles -> rsp_valid/rsp_data stable; req_valid during RESP not accepted.
// - reset_n asserted in WAIT -> all outputs 0 asynchronously, IDLE; subsequent request completes normally.

Source files
------------

// File: rtl/fast_core_indirect_pkg.sv
// Shared definitions for the @R0/@R1 indirect operand reader.
// Holds FSM encoding, address-space constants and the Ri register address helper.
package fast_core_indirect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic       IDATA_SPACE = 1'b0;
    localparam logic       XDATA_SPACE = 1'b1;
    localparam logic [7:0] IDATA_PAGE  = 8'h00;
    localparam logic [7:0] ERR_BYTE    = 8'hFF;

    // R0/R1 of bank b live at internal RAM address b*8 + sel.
    function automatic logic [15:0] ri_addr(input logic [1:0] bank, input logic sel);
        return {11'b0, bank, 2'b00, sel};
    endfunction

endpackage

// File: rtl/fast_core_ri_bypass_sel.sv
// Pointer select for @Ri operands: picks R0/R1 and forwards a same-cycle write
// to that register so the pointer never uses a stale value.
module fast_core_ri_bypass_sel
    import fast_core_indirect_pkg::*;
(
    input  logic [1:0]  bank,
    input  logic [7:0]  r0,
    input  logic [7:0]  r1,
    input  logic        sel,
    input  logic        we,
    input  logic [15:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic [7:0]  ptr
);

    logic hit;

    assign hit = we && (wr_addr == ri_addr(bank, sel));
    assign ptr = hit ? wr_data : (sel ? r1 : r0);

endmodule

// File: rtl/fast_core_indirect_reader.sv
// Resolves @R0/@R1 (and MOVX @Ri) operands: captures the pointer on accept,
// issues one memory read and returns the byte, or 0xFF with rsp_err on timeout.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | req_ready high, waiting for req_valid
//   ST_ISSUE | mem_rd_req strobe high, ack already sampled (zero-wait)
//   ST_WAIT  | waiting for mem_rd_ack, timeout counter running
//   ST_RESP  | rsp_valid held until rsp_ready
module fast_core_indirect_reader
    import fast_core_indirect_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  active_bank_index,
    input  logic [7:0]  R0,
    input  logic [7:0]  R1,
    input  logic [15:0] wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        we,
    input  logic [7:0]  p2_page,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_ri_sel,
    input  logic        req_xdata,
    output logic        mem_rd_req,
    output logic [15:0] mem_rd_addr,
    output logic        mem_rd_xdata,
    input  logic        mem_rd_ack,
    input  logic [7:0]  mem_rd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic [15:0] rsp_addr,
    output logic        rsp_err
);

    localparam logic [8:0] CNT_LAST = 9'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [8:0]  cnt;
    logic [7:0]  ptr;
    logic [15:0] req_addr;
    logic        accept;

    fast_core_ri_bypass_sel u_ri_sel (
        .bank    (active_bank_index),
        .r0      (R0),
        .r1      (R1),
        .sel     (req_ri_sel),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ptr     (ptr)
    );

    assign req_addr = (req_xdata == XDATA_SPACE) ? {p2_page, ptr} : {IDATA_PAGE, ptr};
    assign accept   = (state == ST_IDLE) && req_ready && req_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            req_ready    <= 1'b0;
            mem_rd_req   <= 1'b0;
            mem_rd_addr  <= '0;
            mem_rd_xdata <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_addr     <= '0;
            rsp_err      <= 1'b0;
        end else begin
            mem_rd_req <= 1'b0;
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        state        <= ST_ISSUE;
                        req_ready    <= 1'b0;
                        mem_rd_req   <= 1'b1;
                        mem_rd_addr  <= req_addr;
                        mem_rd_xdata <= req_xdata;
                        cnt          <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (mem_rd_ack) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= mem_rd_data;
                        rsp_err   <= 1'b0;
                        rsp_addr  <= mem_rd_addr;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // An ack in the final timeout cycle still counts as success.
                    if (mem_rd_ack) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= mem_rd_data;
                        rsp_err   <= 1'b0;
                        rsp_addr  <= mem_rd_addr;
                    end else if (cnt == CNT_LAST) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= ERR_BYTE;
                        rsp_err   <= 1'b1;
                        rsp_addr  <= mem_rd_addr;
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fast_core_indirect_reader.sv
// Scoreboard bench for the indirect operand reader: expected reads are queued
// when a request is driven and retired at the response handshake.
module tb_fast_core_indirect_reader;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  bank;
    logic [7:0]  r0, r1;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        we;
    logic [7:0]  p2_page;
    logic        req_valid, req_ready, req_ri_sel, req_xdata;
    logic        mem_rd_req, mem_rd_xdata, mem_rd_ack;
    logic [15:0] mem_rd_addr;
    logic [7:0]  mem_rd_data;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [7:0]  rsp_data;
    logic [15:0] rsp_addr;

    typedef struct {
        logic [15:0] addr;
        logic        xd;
        logic [7:0]  data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   rd_reqs = 0;
    logic s_rsp_valid, s_req_ready;
    logic [7:0] s_rsp_data;

    fast_core_indirect_reader #(.TIMEOUT_CYCLES(T)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .active_bank_index (bank),
        .R0                (r0),
        .R1                (r1),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .we                (we),
        .p2_page           (p2_page),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_ri_sel        (req_ri_sel),
        .req_xdata         (req_xdata),
        .mem_rd_req        (mem_rd_req),
        .mem_rd_addr       (mem_rd_addr),
        .mem_rd_xdata      (mem_rd_xdata),
        .mem_rd_ack        (mem_rd_ack),
        .mem_rd_data       (mem_rd_data),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_data          (rsp_data),
        .rsp_addr          (rsp_addr),
        .rsp_err           (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Sample on the falling edge, then advance to just after the next rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        s_rsp_valid = rsp_valid;
        s_req_ready = req_ready;
        s_rsp_data  = rsp_data;
        if (reset_n && mem_rd_req) begin
            rd_reqs++;
            if (exp_q.size() != 0) begin
                check("rd_addr", {16'h0, mem_rd_addr}, {16'h0, exp_q[$].addr});
                check("rd_xdata", {31'h0, mem_rd_xdata}, {31'h0, exp_q[$].xd});
            end
        end
        if (reset_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rsp_data", {24'h0, rsp_data}, {24'h0, e.data});
                check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                check("rsp_addr", {16'h0, rsp_addr}, {16'h0, e.addr});
            end else begin
                check("sb_depth", exp_q.size(), 1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input logic [1:0] b, input logic [7:0] v0, input logic [7:0] v1,
                          input logic sel, input logic xd, input logic [7:0] p2,
                          input logic bwe, input logic [15:0] baddr, input logic [7:0] bdata,
                          input int k, input logic [7:0] adata, input int hold);
        exp_t e;
        logic [7:0] p;
        int lat;
        int n;
        int reqs0;
        n = 0;
        while (!s_req_ready && n < 20) begin
            step();
            n++;
        end
        p = (bwe && baddr == {11'b0, b, 2'b00, sel}) ? bdata : (sel ? v1 : v0);
        e.addr = xd ? {p2, p} : {8'h00, p};
        e.xd   = xd;
        e.data = (k != 0) ? adata : 8'hFF;
        e.err  = (k == 0);
        reqs0  = rd_reqs;
        bank = b; r0 = v0; r1 = v1; req_ri_sel = sel; req_xdata = xd; p2_page = p2;
        we = bwe; wr_addr = baddr; wr_data = bdata; req_valid = 1'b1;
        exp_q.push_back(e);
        step();
        req_valid = 1'b0;
        lat = -1;
        for (int j = 1; j <= 40; j++) begin
            if (j == 1) begin
                // Disturb every input the captured address came from.
                bank = ~b; r0 = ~v0; r1 = ~v1; p2_page = ~p2;
                we = 1'b1; wr_addr = {11'b0, b, 2'b00, sel}; wr_data = 8'hEE;
            end else begin
                we = 1'b0;
            end
            mem_rd_ack  = (k != 0) && (j == k);
            mem_rd_data = (j == k) ? adata : 8'h5E;
            step();
            if (s_rsp_valid) begin
                lat = j;
                break;
            end
        end
        mem_rd_ack = 1'b0;
        we = 1'b0;
        check("latency", lat, (k != 0) ? k + 1 : T + 2);
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            step();
            check("hold_valid", {31'h0, s_rsp_valid}, 32'h1);
            check("hold_data", {24'h0, s_rsp_data}, {24'h0, e.data});
            check("hold_ready", {31'h0, s_req_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        step();
        check("post_valid", {31'h0, s_rsp_valid}, 32'h0);
        check("post_ready", {31'h0, s_req_ready}, 32'h1);
        check("rd_req_cnt", rd_reqs - reqs0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqs0;
        exp_t e;
        reset_n = 1'b0; bank = 2'd0; r0 = 8'h0; r1 = 8'h0; wr_addr = 16'h0; wr_data = 8'h0;
        we = 1'b0; p2_page = 8'h0; req_valid = 1'b0; req_ri_sel = 1'b0; req_xdata = 1'b0;
        mem_rd_ack = 1'b0; mem_rd_data = 8'h0; rsp_ready = 1'b0;
        s_rsp_valid = 1'b0; s_req_ready = 1'b0; s_rsp_data = 8'h0;
        repeat (2) @(negedge clk);
        check("rst_ctl", {27'h0, req_ready, mem_rd_req, mem_rd_xdata, rsp_valid, rsp_err}, 32'h0);
        check("rst_addr", {mem_rd_addr, rsp_addr}, 32'h0);
        check("rst_data", {24'h0, rsp_data}, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        step();
        step();
        check("rst_ready", {31'h0, s_req_ready}, 32'h1);

        do_txn(2'd2, 8'h11, 8'h45, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0, 8'h0, 1, 8'h3C, 0);
        do_txn(2'd1, 8'h10, 8'h22, 1'b0, 1'b0, 8'h00, 1'b1, 16'h0008, 8'h77, 2, 8'h5A, 0);
        do_txn(2'd1, 8'h10, 8'h22, 1'b0, 1'b0, 8'h00, 1'b1, 16'h0010, 8'h77, 1, 8'hC3, 0);
        do_txn(2'd0, 8'hA0, 8'h01, 1'b0, 1'b1, 8'h12, 1'b0, 16'h0, 8'h0, 5, 8'h99, 0);
        do_txn(2'd3, 8'h02, 8'h6B, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0, 8'h0, 0, 8'h00, 0);

        reqs0 = rd_reqs;
        mem_rd_ack = 1'b1; mem_rd_data = 8'h42;
        step();
        mem_rd_ack = 1'b0;
        step();
        check("stray_valid", {31'h0, s_rsp_valid}, 32'h0);
        check("stray_ready", {31'h0, s_req_ready}, 32'h1);
        check("stray_rdreq", rd_reqs - reqs0, 0);

        do_txn(2'd0, 8'h7E, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0, 8'h0, T + 1, 8'hA5, 0);
        do_txn(2'd3, 8'h04, 8'h81, 1'b1, 1'b1, 8'h80, 1'b1, 16'h0019, 8'h3E, 3, 8'h6D, 4);

        // Reset while waiting for an ack that never comes.
        e.addr = 16'h0033; e.xd = 1'b0; e.data = 8'hFF; e.err = 1'b1;
        exp_q.push_back(e);
        bank = 2'd0; r0 = 8'h33; req_ri_sel = 1'b0; req_xdata = 1'b0; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (4) step();
        reset_n = 1'b0;
        #2;
        check("arst_ctl", {27'h0, req_ready, mem_rd_req, mem_rd_xdata, rsp_valid, rsp_err}, 32'h0);
        check("arst_addr", {mem_rd_addr, rsp_addr}, 32'h0);
        check("arst_data", {24'h0, rsp_data}, 32'h0);
        exp_q.delete();
        step();
        reset_n = 1'b1;
        mem_rd_ack = 1'b1; mem_rd_data = 8'h24;
        step();
        mem_rd_ack = 1'b0;
        step();
        step();
        check("late_ack_valid", {31'h0, s_rsp_valid}, 32'h0);
        check("late_ack_ready", {31'h0, s_req_ready}, 32'h1);
        do_txn(2'd1, 8'h5C, 8'h9D, 1'b1, 1'b1, 8'h3F, 1'b0, 16'h0, 8'h0, 2, 8'hB7, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
